// File: rtl/dmi_responder.sv
// dmi_responder: debug-module-side DMI target. It accepts one request at a
// time, waits a programmable number of cycles, then answers from a small
// local register space holding scratch/data registers and a write counter.
module dmi_responder #(
  parameter int NumRegs     = 4,
  parameter int RespLatency = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [40:0]             dmi_req_i,
  input  logic                    dmi_req_valid_i,
  output logic                    dmi_req_ready_o,
  output logic [33:0]             dmi_resp_o,
  output logic                    dmi_resp_valid_o,
  input  logic                    dmi_resp_ready_i,
  output logic [32*NumRegs-1:0]   regs_o,
  output logic [31:0]             wr_count_o
);

  localparam logic [1:0] OP_NOP      = 2'd0;
  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_WRITE    = 2'd2;
  localparam logic [1:0] RESP_OK     = 2'd0;
  localparam logic [1:0] RESP_FAILED = 2'd2;
  localparam logic [6:0] REG_BASE    = 7'h04;
  localparam logic [6:0] WRCOUNT_ADR = 7'h11;
  localparam logic [6:0] NUM_REGS_A  = 7'(NumRegs);
  localparam logic [3:0] LATENCY     = 4'(RespLatency);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [6:0]    addr_q;
  logic [1:0]    op_q;
  logic [31:0]   data_q;
  logic [3:0]    cnt_q;
  logic [31:0]   regs_q [NumRegs];
  logic [31:0]   wr_count_q;
  logic [33:0]   resp_q;

  logic          accept;
  logic          exec;
  logic [6:0]    reg_off;
  logic          reg_hit;
  logic [31:0]   rd_data;
  logic [NumRegs-1:0] reg_we;
  logic          wr_inc;
  logic [1:0]    exec_resp;
  logic [31:0]   exec_data;

  assign accept = dmi_req_valid_i & dmi_req_ready_o;
  // The op executes on the edge that leaves WAIT.
  assign exec   = (state_q == WAIT) && (cnt_q == 4'd0);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; ready is held low while reset is asserted.
  always_comb begin
    state_d          = state_q;
    dmi_req_ready_o  = 1'b0;
    dmi_resp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmi_req_ready_o = ~rst_i;
        if (dmi_req_valid_i && !rst_i) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        dmi_resp_valid_o = 1'b1;
        if (dmi_resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address decode and op execution result for the latched request.
  always_comb begin
    reg_off   = addr_q - REG_BASE;
    reg_hit   = (addr_q >= REG_BASE) && (reg_off < NUM_REGS_A);
    rd_data   = '0;
    reg_we    = '0;
    wr_inc    = 1'b0;
    exec_resp = RESP_OK;
    exec_data = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (reg_off == 7'(i)) rd_data = regs_q[i];
    end
    case (op_q)
      OP_NOP: begin
        exec_resp = RESP_OK;
      end
      OP_READ: begin
        if (reg_hit)                    exec_data = rd_data;
        else if (addr_q == WRCOUNT_ADR) exec_data = wr_count_q;
        else                            exec_resp = RESP_FAILED;
      end
      OP_WRITE: begin
        if (reg_hit) begin
          wr_inc = 1'b1;
          for (int i = 0; i < NumRegs; i++) begin
            if (reg_off == 7'(i)) reg_we[i] = 1'b1;
          end
        end else begin
          exec_resp = RESP_FAILED;
        end
      end
      default: exec_resp = RESP_FAILED;
    endcase
  end

  // Request latch and wait counter; request inputs are only sampled on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      op_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      addr_q <= dmi_req_i[40:34];
      op_q   <= dmi_req_i[33:32];
      data_q <= dmi_req_i[31:0];
      cnt_q  <= LATENCY;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q  <= cnt_q - 4'd1;
    end
  end

  // Register file, write counter and response register, all updated on exec.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
      resp_q     <= '0;
    end else if (exec) begin
      resp_q <= {exec_data, exec_resp};
      for (int i = 0; i < NumRegs; i++) begin
        if (reg_we[i]) regs_q[i] <= data_q;
      end
      if (wr_inc) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign dmi_resp_o = resp_q;
  assign wr_count_o = wr_count_q;

  for (genvar g = 0; g < NumRegs; g++) begin : g_regs
    assign regs_o[32*g +: 32] = regs_q[g];
  end

endmodule
